// File: rtl/pix_work_gen.sv
// pix_work_gen: walks an x_max by y_max pixel grid (raster or column-major)
// and hands one coordinate per cycle to the next ready worker, chosen by
// round-robin from a registered pointer.
module pix_work_gen #(
  parameter int NUM_CNT_BITS = 10,
  parameter int NUM_WORKERS  = 4,
  parameter int WID_BITS     = 2
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      clear,
  input  logic                      start,
  input  logic                      mode,
  input  logic [NUM_CNT_BITS-1:0]   x_max,
  input  logic [NUM_CNT_BITS-1:0]   y_max,
  input  logic [NUM_WORKERS-1:0]    worker_ready,
  output logic [NUM_WORKERS-1:0]    work_valid,
  output logic [NUM_CNT_BITS-1:0]   work_x,
  output logic [NUM_CNT_BITS-1:0]   work_y,
  output logic [WID_BITS-1:0]       work_id,
  output logic [2*NUM_CNT_BITS-1:0] pix_count,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = 2 * NUM_CNT_BITS;
  localparam logic [NUM_CNT_BITS-1:0] C_ONE   = NUM_CNT_BITS'(1);
  localparam logic [WID_BITS:0]       NW_WIDE = (WID_BITS+1)'(NUM_WORKERS);
  localparam logic [WID_BITS-1:0]     LAST_ID = WID_BITS'(NUM_WORKERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] x_q, x_d;
  logic [NUM_CNT_BITS-1:0] y_q, y_d;
  logic [NUM_CNT_BITS-1:0] xmax_q, xmax_d;
  logic [NUM_CNT_BITS-1:0] ymax_q, ymax_d;
  logic                    mode_q, mode_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WID_BITS-1:0]     rr_q, rr_d;

  logic                    gnt_found;
  logic [WID_BITS-1:0]     gnt_idx;
  logic                    last_pix;
  logic                    x_wrap;
  logic                    y_wrap;
  logic                    zero_grid;

  assign x_wrap    = (x_q == xmax_q - C_ONE);
  assign y_wrap    = (y_q == ymax_q - C_ONE);
  assign last_pix  = x_wrap && y_wrap;
  assign zero_grid = (x_max == '0) || (y_max == '0);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides everything, including a transfer.
  // NOTE: every always_comb output gets a default first, otherwise paths
  // that do not assign it infer a latch.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = zero_grid ? ST_DONE : ST_RUN;
        ST_RUN:           if (gnt_found && last_pix) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // Round-robin search: first ready worker at or after rr_q, wrapping.
  always_comb begin
    logic [WID_BITS:0] k;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    k         = '0;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < NUM_WORKERS; i++) begin
        k = {1'b0, rr_q} + (WID_BITS+1)'(i);
        if (k >= NW_WIDE) k = k - NW_WIDE;
        if (!gnt_found && worker_ready[k[WID_BITS-1:0]]) begin
          gnt_found = 1'b1;
          gnt_idx   = k[WID_BITS-1:0];
        end
      end
    end
  end

  // Output decode: one-hot grant, worker index and status flags.
  always_comb begin
    work_valid = '0;
    work_id    = '0;
    if (gnt_found) begin
      work_valid = NUM_WORKERS'(1) << gnt_idx;
      work_id    = gnt_idx;
    end
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    work_x    = x_q;
    work_y    = y_q;
    pix_count = cnt_q;
  end

  // Datapath next-state: config latch, coordinate walk, count, pointer.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    xmax_d = xmax_q;
    ymax_d = ymax_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    rr_d   = rr_q;
    if (clear) begin
      x_d   = '0;
      y_d   = '0;
      cnt_d = '0;
      rr_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          // A new frame keeps the pointer so fairness carries across frames.
          if (start) begin
            xmax_d = x_max;
            ymax_d = y_max;
            mode_d = mode;
            x_d    = '0;
            y_d    = '0;
            cnt_d  = '0;
          end
        end
        ST_RUN: begin
          if (gnt_found) begin
            cnt_d = cnt_q + CW'(1);
            rr_d  = (gnt_idx == LAST_ID) ? '0 : gnt_idx + WID_BITS'(1);
            // The last pixel's coordinates stay visible in DONE.
            if (!last_pix) begin
              if (!mode_q) begin
                if (x_wrap) begin
                  x_d = '0;
                  y_d = y_q + C_ONE;
                end else begin
                  x_d = x_q + C_ONE;
                end
              end else begin
                if (y_wrap) begin
                  y_d = '0;
                  x_d = x_q + C_ONE;
                end else begin
                  y_d = y_q + C_ONE;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_q    <= '0;
      y_q    <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      rr_q   <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      xmax_q <= xmax_d;
      ymax_q <= ymax_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: tb/tb_pix_work_gen.sv
// Self-checking bench for pix_work_gen: a queue of expected pixels built from
// nested loops plus a round-robin pointer model predicts every grant.
module tb_pix_work_gen;

  localparam int N  = 10;
  localparam int NW = 4;
  localparam int WB = 2;
  localparam int CW = 2 * N;

  typedef struct {
    int x;
    int y;
  } pix_t;

  logic          clk = 1'b0;
  logic          n_rst, clear, start, mode;
  logic [N-1:0]  x_max, y_max;
  logic [NW-1:0] worker_ready, work_valid;
  logic [N-1:0]  work_x, work_y;
  logic [WB-1:0] work_id;
  logic [CW-1:0] pix_count;
  logic          busy, done;

  int n_pass = 0;
  int n_chk  = 0;
  int m_rr   = 0;

  pix_work_gen #(.NUM_CNT_BITS(N), .NUM_WORKERS(NW), .WID_BITS(WB)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .start(start), .mode(mode),
    .x_max(x_max), .y_max(y_max), .worker_ready(worker_ready),
    .work_valid(work_valid), .work_x(work_x), .work_y(work_y),
    .work_id(work_id), .pix_count(pix_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbiter: first ready worker scanning upward from rr, modulo NW.
  function automatic int model_grant(input logic [NW-1:0] rdy, input int rr);
    for (int i = 0; i < NW; i++)
      if (rdy[(rr + i) % NW]) return (rr + i) % NW;
    return -1;
  endfunction

  task automatic test_reset();
    n_rst = 1'b0; clear = 1'b0; start = 1'b0; mode = 1'b0;
    x_max = '0; y_max = '0; worker_ready = '1;
    #12;
    n_chk++;
    if ({work_valid, work_id, busy, done} !== '0)
      $display("FAIL reset_ctrl got %b want 0", {work_valid, work_id, busy, done});
    else n_pass++;
    n_chk++;
    if ({work_x, work_y, pix_count} !== '0)
      $display("FAIL reset_data got %h want 0", {work_x, work_y, pix_count});
    else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
    m_rr = 0;
    step();
  endtask

  // Runs one frame from IDLE/DONE. rnd: random ready lines plus junk on
  // config/start during RUN. stall_at: item count at which ready drops to 0
  // for three cycles. thru: require one item per cycle.
  task automatic test_frame(input bit m, input int xm, input int ym, input bit rnd,
                            input logic [NW-1:0] rdy_fix, input int stall_at, input bit thru);
    pix_t q[$];
    pix_t p;
    logic [NW-1:0] rdy, exp_v;
    int g, cnt, cycles, stall_left, budget;
    q.delete();
    if (!m) begin
      for (int y = 0; y < ym; y++) for (int x = 0; x < xm; x++) begin p.x = x; p.y = y; q.push_back(p); end
    end else begin
      for (int x = 0; x < xm; x++) for (int y = 0; y < ym; y++) begin p.x = x; p.y = y; q.push_back(p); end
    end
    start = 1'b1; mode = m; x_max = N'(xm); y_max = N'(ym); worker_ready = '0;
    step();
    start = 1'b0;
    cnt = 0; cycles = 0; stall_left = 3; budget = xm * ym * 20 + 50;
    while (q.size() > 0 && cycles < budget) begin
      rdy = rnd ? NW'($urandom_range(0, (1 << NW) - 1)) : rdy_fix;
      if (cnt == stall_at && stall_left > 0) begin
        rdy = '0;
        stall_left--;
      end
      worker_ready = rdy;
      if (rnd) begin
        x_max = N'($urandom); y_max = N'($urandom);
        mode = 1'($urandom); start = 1'($urandom);
      end
      #1;
      g = model_grant(rdy, m_rr);
      exp_v = (g < 0) ? '0 : NW'(1) << g;
      n_chk++;
      if (work_valid !== exp_v) $display("FAIL valid item%0d got %b want %b", cnt, work_valid, exp_v);
      else n_pass++;
      n_chk++;
      if (work_id !== WB'((g < 0) ? 0 : g)) $display("FAIL work_id item%0d got %0d want %0d", cnt, work_id, (g < 0) ? 0 : g);
      else n_pass++;
      n_chk++;
      if (work_x !== N'(q[0].x) || work_y !== N'(q[0].y))
        $display("FAIL coord item%0d got (%0d,%0d) want (%0d,%0d)", cnt, work_x, work_y, q[0].x, q[0].y);
      else n_pass++;
      n_chk++;
      if (pix_count !== CW'(cnt) || busy !== 1'b1)
        $display("FAIL count_busy got %0d/%b want %0d/1", pix_count, busy, cnt);
      else n_pass++;
      if (g >= 0) begin
        void'(q.pop_front());
        cnt++;
        m_rr = (g + 1) % NW;
      end
      step();
      cycles++;
    end
    start = 1'b0; worker_ready = '1;
    n_chk++;
    if (q.size() != 0) $display("FAIL frame_timeout got %0d left want 0", q.size());
    else n_pass++;
    #1;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || work_valid !== '0)
      $display("FAIL done_state got d%b b%b v%b want d1 b0 v0", done, busy, work_valid);
    else n_pass++;
    n_chk++;
    if (pix_count !== CW'(xm * ym)) $display("FAIL final_count got %0d want %0d", pix_count, xm * ym);
    else n_pass++;
    n_chk++;
    if (work_x !== N'(xm - 1) || work_y !== N'(ym - 1))
      $display("FAIL last_coord got (%0d,%0d) want (%0d,%0d)", work_x, work_y, xm - 1, ym - 1);
    else n_pass++;
    if (thru) begin
      n_chk++;
      if (cycles != xm * ym) $display("FAIL throughput got %0d cycles want %0d", cycles, xm * ym);
      else n_pass++;
    end
  endtask

  task automatic test_pointer_wrap();
    start = 1'b1; mode = 1'b0; x_max = N'(10); y_max = N'(10); worker_ready = '0;
    step();
    start = 1'b0;
    worker_ready = 4'b0001;
    #1;
    n_chk++;
    if (work_valid !== 4'b0001) $display("FAIL ptr_setup got %b want 0001", work_valid);
    else n_pass++;
    step();
    worker_ready = 4'b1001;
    #1;
    n_chk++;
    if (work_valid !== 4'b1000 || work_id !== 2'd3) $display("FAIL ptr_skip got %b/%0d want 1000/3", work_valid, work_id);
    else n_pass++;
    step();
    #1;
    n_chk++;
    if (work_valid !== 4'b0001 || work_id !== 2'd0) $display("FAIL ptr_wrap got %b/%0d want 0001/0", work_valid, work_id);
    else n_pass++;
    step();
    clear = 1'b1; worker_ready = '0;
    step();
    clear = 1'b0;
    m_rr = 0;
    #1;
    n_chk++;
    if (pix_count !== '0 || busy !== 1'b0) $display("FAIL ptr_clear got %0d/%b want 0/0", pix_count, busy);
    else n_pass++;
  endtask

  task automatic test_clear();
    logic [NW-1:0] exp_v;
    start = 1'b1; mode = 1'b0; x_max = N'(10); y_max = N'(10); worker_ready = '0;
    step();
    start = 1'b0; worker_ready = '1;
    for (int i = 0; i < 37; i++) begin
      step();
      m_rr = (m_rr + 1) % NW;
    end
    #1;
    n_chk++;
    if (pix_count !== CW'(37) || work_x !== N'(7) || work_y !== N'(3))
      $display("FAIL clear_pre got %0d (%0d,%0d) want 37 (7,3)", pix_count, work_x, work_y);
    else n_pass++;
    clear = 1'b1; start = 1'b1;
    #1;
    exp_v = NW'(1) << m_rr;
    n_chk++;
    if (work_valid !== exp_v) $display("FAIL clear_presented got %b want %b", work_valid, exp_v);
    else n_pass++;
    step();
    clear = 1'b0; start = 1'b0;
    m_rr = 0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || work_valid !== '0)
      $display("FAIL clear_state got b%b d%b v%b want b0 d0 v0", busy, done, work_valid);
    else n_pass++;
    n_chk++;
    if (pix_count !== '0 || work_x !== '0 || work_y !== '0)
      $display("FAIL clear_data got %0d (%0d,%0d) want 0 (0,0)", pix_count, work_x, work_y);
    else n_pass++;
  endtask

  task automatic test_zero_grid(input int xm, input int ym);
    start = 1'b1; mode = 1'b0; x_max = N'(xm); y_max = N'(ym); worker_ready = '1;
    step();
    start = 1'b0;
    #1;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || pix_count !== '0)
      $display("FAIL zero_grid %0dx%0d got d%b b%b c%0d want d1 b0 c0", xm, ym, done, busy, pix_count);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (work_valid !== '0) $display("FAIL zero_grid_valid got %b want 0", work_valid);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; mode = 1'b1; x_max = N'(6); y_max = N'(6); worker_ready = '0;
    step();
    start = 1'b0; worker_ready = '1;
    step();
    step();
    #2;
    n_rst = 1'b0;
    #1;
    n_chk++;
    if ({work_valid, work_id, busy, done, work_x, work_y, pix_count} !== '0)
      $display("FAIL async_reset got %h want 0", {work_valid, work_id, busy, done, work_x, work_y, pix_count});
    else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
    m_rr = 0;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame(1'b0, 10, 10, 1'b0, 4'b1111, -1, 1'b1);
    test_frame(1'b1, 10, 10, 1'b0, 4'b1111, -1, 1'b1);
    test_frame(1'b0, 3, 2, 1'b0, 4'b0100, 3, 1'b0);
    test_pointer_wrap();
    test_clear();
    test_frame(1'b0, 4, 3, 1'b0, 4'b1111, -1, 1'b1);
    test_frame(1'b1, 1, 1, 1'b0, 4'b1111, -1, 1'b1);
    test_zero_grid(0, 5);
    test_zero_grid(7, 0);
    test_async_reset();
    test_frame(1'b1, 1, 5, 1'b0, 4'b0110, -1, 1'b1);
    for (int i = 0; i < 8; i++)
      test_frame(1'($urandom), $urandom_range(1, 6), $urandom_range(1, 6), 1'b1, '0, -1, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
